// File: rtl/lcm_pkg.sv
// Shared definitions for the LCM report path: UM word geometry, header codes
// and the packet arbiter state encoding.
package lcm_pkg;

  localparam int UM_W = 134;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_BODY = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT0  = 2'd1,
    ARB_GNT1  = 2'd2,
    ARB_ABORT = 2'd3
  } arb_state_e;

endpackage

// File: rtl/lr_arb_watchdog.sv
// Grant watchdog: counts idle granted cycles, first before the head word
// (start timeout) and then between words of the packet (gap timeout).
module lr_arb_watchdog #(
  parameter int START_TO = 8,
  parameter int GAP_TO   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic wr_i,
  output logic to_start_o,
  output logic to_gap_o
);

  localparam int MAX_TO = (START_TO > GAP_TO) ? START_TO : GAP_TO;
  localparam int CNT_W  = $clog2(MAX_TO + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             started_q, started_d;

  // The pulse fires during the last allowed idle cycle so the grant drops on that edge.
  assign to_start_o = active_i && !started_q && !wr_i && (cnt_q == CNT_W'(START_TO - 1));
  assign to_gap_o   = active_i &&  started_q && !wr_i && (cnt_q == CNT_W'(GAP_TO - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cnt_d     = cnt_q;
    started_d = started_q;
    if (!active_i) begin
      cnt_d     = '0;
      started_d = 1'b0;
    end else if (wr_i) begin
      cnt_d     = '0;
      started_d = 1'b1;
    end else if (to_start_o || to_gap_o) begin
      cnt_d     = '0;
      started_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      started_q <= started_d;
    end
  end

endmodule

// File: rtl/lr_pkt_arbiter.sv
// Two-source, packet-granular round-robin arbiter onto the shared UM bus,
// with start/gap watchdogs and a forced invalid tail on mid-packet stalls.
module lr_pkt_arbiter
  import lcm_pkg::*;
#(
  parameter int START_TO    = 8,
  parameter int GAP_TO      = 4,
  parameter bit PRIO1_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in0_req,
  input  logic            in0_data_wr,
  input  logic [UM_W-1:0] in0_data,
  input  logic            in0_data_valid,
  input  logic            in0_data_valid_wr,
  output logic            in0_gnt,
  input  logic            in1_req,
  input  logic            in1_data_wr,
  input  logic [UM_W-1:0] in1_data,
  input  logic            in1_data_valid,
  input  logic            in1_data_valid_wr,
  output logic            in1_gnt,
  output logic            out_data_wr,
  output logic [UM_W-1:0] out_data,
  output logic            out_data_valid,
  output logic            out_data_valid_wr,
  output logic [15:0]     abort_cnt,
  output logic [31:0]     pkt_cnt_0,
  output logic [31:0]     pkt_cnt_1
);

  localparam logic [1:0] ST_IDLE  = ARB_IDLE;
  localparam logic [1:0] ST_GNT0  = ARB_GNT0;
  localparam logic [1:0] ST_GNT1  = ARB_GNT1;
  localparam logic [1:0] ST_ABORT = ARB_ABORT;

  logic [1:0]      state_q, state_d;
  logic            rr_q, rr_d;          // 1: source 1 wins the next tie
  logic            out_wr_q, out_wr_d;
  logic [UM_W-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_vwr_q, out_vwr_d;
  logic [15:0]     abort_cnt_q, abort_cnt_d;
  logic [31:0]     pkt_cnt_0_q, pkt_cnt_0_d;
  logic [31:0]     pkt_cnt_1_q, pkt_cnt_1_d;

  logic            sel1, granted;
  logic            g_wr, g_valid, g_vwr;
  logic [UM_W-1:0] g_data;
  logic            acc_wr, acc_tail;
  logic            to_start, to_gap;

  assign sel1    = (state_q == ST_GNT1);
  assign granted = (state_q == ST_GNT0) || sel1;
  assign in0_gnt = (state_q == ST_GNT0);
  assign in1_gnt = sel1;

  assign g_wr     = sel1 ? in1_data_wr       : in0_data_wr;
  assign g_data   = sel1 ? in1_data          : in0_data;
  assign g_valid  = sel1 ? in1_data_valid    : in0_data_valid;
  assign g_vwr    = sel1 ? in1_data_valid_wr : in0_data_valid_wr;
  assign acc_wr   = granted && g_wr;
  assign acc_tail = acc_wr && (g_data[UM_W-1 -: 2] == HDR_TAIL);

  lr_arb_watchdog #(
    .START_TO (START_TO),
    .GAP_TO   (GAP_TO)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .active_i   (granted),
    .wr_i       (acc_wr),
    .to_start_o (to_start),
    .to_gap_o   (to_gap)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (in1_req && (!in0_req || rr_q)) state_d = ST_GNT1;
        else if (in0_req)                  state_d = ST_GNT0;
      end
      ST_GNT0, ST_GNT1: begin
        // Any way out of a grant hands the next tie to the other source.
        if (acc_tail || to_start) begin
          state_d = ST_IDLE;
          rr_d    = !sel1;
        end else if (to_gap) begin
          state_d = ST_ABORT;
          rr_d    = !sel1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_wr_d    = 1'b0;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    out_vwr_d   = 1'b0;
    if (state_q == ST_ABORT) begin
      out_wr_d   = 1'b1;
      out_data_d = {HDR_TAIL, {(UM_W-2){1'b0}}};
      out_vwr_d  = 1'b1;
    end else if (acc_wr) begin
      out_wr_d    = 1'b1;
      out_data_d  = g_data;
      out_valid_d = g_valid;
      out_vwr_d   = g_vwr;
    end
  end

  always_comb begin
    abort_cnt_d = abort_cnt_q;
    pkt_cnt_0_d = pkt_cnt_0_q;
    pkt_cnt_1_d = pkt_cnt_1_q;
    if ((state_q == ST_ABORT) && (abort_cnt_q != 16'hFFFF)) abort_cnt_d = abort_cnt_q + 16'd1;
    if (acc_tail && !sel1) pkt_cnt_0_d = pkt_cnt_0_q + 32'd1;
    if (acc_tail &&  sel1) pkt_cnt_1_d = pkt_cnt_1_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= PRIO1_FIRST;
      out_wr_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_vwr_q   <= 1'b0;
      abort_cnt_q <= '0;
      pkt_cnt_0_q <= '0;
      pkt_cnt_1_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      out_wr_q    <= out_wr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_vwr_q   <= out_vwr_d;
      abort_cnt_q <= abort_cnt_d;
      pkt_cnt_0_q <= pkt_cnt_0_d;
      pkt_cnt_1_q <= pkt_cnt_1_d;
    end
  end

  assign out_data_wr       = out_wr_q;
  assign out_data          = out_data_q;
  assign out_data_valid    = out_valid_q;
  assign out_data_valid_wr = out_vwr_q;
  assign abort_cnt         = abort_cnt_q;
  assign pkt_cnt_0         = pkt_cnt_0_q;
  assign pkt_cnt_1         = pkt_cnt_1_q;

endmodule

// File: tb/tb_lr_pkt_arbiter.sv
// Directed bench for lr_pkt_arbiter: single packet, tie, fairness, gap abort,
// start timeout and reset during a packet, with hand-computed expectations.
module tb_lr_pkt_arbiter;
  import lcm_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in0_req, in0_data_wr, in0_data_valid, in0_data_valid_wr, in0_gnt;
  logic [133:0] in0_data;
  logic         in1_req, in1_data_wr, in1_data_valid, in1_data_valid_wr, in1_gnt;
  logic [133:0] in1_data;
  logic         out_data_wr, out_data_valid, out_data_valid_wr;
  logic [133:0] out_data;
  logic [15:0]  abort_cnt;
  logic [31:0]  pkt_cnt_0, pkt_cnt_1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  lr_pkt_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .in0_req           (in0_req),
    .in0_data_wr       (in0_data_wr),
    .in0_data          (in0_data),
    .in0_data_valid    (in0_data_valid),
    .in0_data_valid_wr (in0_data_valid_wr),
    .in0_gnt           (in0_gnt),
    .in1_req           (in1_req),
    .in1_data_wr       (in1_data_wr),
    .in1_data          (in1_data),
    .in1_data_valid    (in1_data_valid),
    .in1_data_valid_wr (in1_data_valid_wr),
    .in1_gnt           (in1_gnt),
    .out_data_wr       (out_data_wr),
    .out_data          (out_data),
    .out_data_valid    (out_data_valid),
    .out_data_valid_wr (out_data_valid_wr),
    .abort_cnt         (abort_cnt),
    .pkt_cnt_0         (pkt_cnt_0),
    .pkt_cnt_1         (pkt_cnt_1)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [133:0] mk(input logic [1:0] hdr, input logic [31:0] tag);
    return {hdr, 100'b0, tag};
  endfunction

  // Observed output word packed as {wr, valid, valid_wr, data}.
  function automatic logic [136:0] outw();
    return {out_data_wr, out_data_valid, out_data_valid_wr, out_data};
  endfunction

  task automatic drive(input int src, input logic wr, input logic [133:0] d,
                       input logic v, input logic vw);
    if (src == 0) begin
      in0_data_wr = wr; in0_data = d; in0_data_valid = v; in0_data_valid_wr = vw;
    end else begin
      in1_data_wr = wr; in1_data = d; in1_data_valid = v; in1_data_valid_wr = vw;
    end
  endtask

  task automatic quiet();
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in0_req = 1'b0; in1_req = 1'b0;
    quiet();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in0_req = 1'b0; in1_req = 1'b0;
    quiet();
    step();
    step();
    checks++; if (outw() !== 137'd0) $display("FAIL reset_out: got %h want 0", outw()); else passed++;
    checks++; if ({in0_gnt, in1_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {in0_gnt, in1_gnt}); else passed++;
    checks++; if ({abort_cnt, pkt_cnt_0, pkt_cnt_1} !== 80'd0)
      $display("FAIL reset_cnt: got %h want 0", {abort_cnt, pkt_cnt_0, pkt_cnt_1}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [133:0] h, b, t;
    h = mk(HDR_HEAD, 32'h11); b = mk(HDR_BODY, 32'h12); t = mk(HDR_TAIL, 32'h13);
    do_reset();
    in0_req = 1'b1;
    step();
    checks++; if ({in0_gnt, in1_gnt} !== 2'b10) $display("FAIL single_gnt: got %b want 10", {in0_gnt, in1_gnt}); else passed++;
    checks++; if (outw() !== 137'd0) $display("FAIL single_idle: got %h want 0", outw()); else passed++;
    drive(0, 1'b1, h, 1'b0, 1'b0);
    step();
    checks++; if (outw() !== {3'b100, h}) $display("FAIL single_head: got %h want %h", outw(), {3'b100, h}); else passed++;
    drive(0, 1'b1, b, 1'b0, 1'b0);
    step();
    checks++; if (outw() !== {3'b100, b}) $display("FAIL single_body: got %h want %h", outw(), {3'b100, b}); else passed++;
    drive(0, 1'b1, t, 1'b1, 1'b1);
    in0_req = 1'b0;
    step();
    checks++; if (outw() !== {3'b111, t}) $display("FAIL single_tail: got %h want %h", outw(), {3'b111, t}); else passed++;
    checks++; if ({in0_gnt, in1_gnt} !== 2'b00) $display("FAIL single_gnt_drop: got %b want 00", {in0_gnt, in1_gnt}); else passed++;
    checks++; if (pkt_cnt_0 !== 32'd1) $display("FAIL single_pkt0: got %0d want 1", pkt_cnt_0); else passed++;
    quiet();
    step();
    checks++; if (outw() !== 137'd0) $display("FAIL single_after: got %h want 0", outw()); else passed++;
  endtask

  task automatic test_tie();
    logic [133:0] h0, t0, h1, t1;
    h0 = mk(HDR_HEAD, 32'h31); t0 = mk(HDR_TAIL, 32'h32);
    h1 = mk(HDR_HEAD, 32'h21); t1 = mk(HDR_TAIL, 32'h22);
    do_reset();
    in0_req = 1'b1; in1_req = 1'b1;
    step();
    checks++; if ({in0_gnt, in1_gnt} !== 2'b01) $display("FAIL tie_first_gnt: got %b want 01", {in0_gnt, in1_gnt}); else passed++;
    drive(1, 1'b1, h1, 1'b0, 1'b0);
    drive(0, 1'b1, mk(HDR_HEAD, 32'hBAD), 1'b1, 1'b1);
    step();
    checks++; if (outw() !== {3'b100, h1}) $display("FAIL tie_head1: got %h want %h", outw(), {3'b100, h1}); else passed++;
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b1, t1, 1'b1, 1'b1);
    in1_req = 1'b0;
    step();
    checks++; if (outw() !== {3'b111, t1}) $display("FAIL tie_tail1: got %h want %h", outw(), {3'b111, t1}); else passed++;
    checks++; if (pkt_cnt_1 !== 32'd1) $display("FAIL tie_pkt1: got %0d want 1", pkt_cnt_1); else passed++;
    quiet();
    step();
    checks++; if (outw() !== 137'd0) $display("FAIL tie_gap: got %h want 0", outw()); else passed++;
    checks++; if ({in0_gnt, in1_gnt} !== 2'b10) $display("FAIL tie_second_gnt: got %b want 10", {in0_gnt, in1_gnt}); else passed++;
    drive(0, 1'b1, h0, 1'b0, 1'b0);
    step();
    checks++; if (outw() !== {3'b100, h0}) $display("FAIL tie_head0: got %h want %h", outw(), {3'b100, h0}); else passed++;
    drive(0, 1'b1, t0, 1'b1, 1'b1);
    in0_req = 1'b0;
    step();
    checks++; if (outw() !== {3'b111, t0}) $display("FAIL tie_tail0: got %h want %h", outw(), {3'b111, t0}); else passed++;
    checks++; if ({pkt_cnt_0, pkt_cnt_1} !== {32'd1, 32'd1})
      $display("FAIL tie_counts: got %0d/%0d want 1/1", pkt_cnt_0, pkt_cnt_1); else passed++;
    quiet();
    step();
  endtask

  task automatic test_fairness();
    int           src;
    logic [1:0]   exp_g;
    logic [133:0] h, t;
    do_reset();
    in0_req = 1'b1; in1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      src   = (i % 2 == 0) ? 1 : 0;
      exp_g = (src == 1) ? 2'b01 : 2'b10;
      h = mk(HDR_HEAD, 32'(100 + i));
      t = mk(HDR_TAIL, 32'(200 + i));
      step();
      checks++; if ({in0_gnt, in1_gnt} !== exp_g)
        $display("FAIL fair_gnt_%0d: got %b want %b", i, {in0_gnt, in1_gnt}, exp_g); else passed++;
      drive(src, 1'b1, h, 1'b0, 1'b0);
      step();
      checks++; if (outw() !== {3'b100, h}) $display("FAIL fair_head_%0d: got %h want %h", i, outw(), {3'b100, h}); else passed++;
      drive(src, 1'b1, t, 1'b1, 1'b1);
      step();
      checks++; if (outw() !== {3'b111, t}) $display("FAIL fair_tail_%0d: got %h want %h", i, outw(), {3'b111, t}); else passed++;
      drive(src, 1'b0, '0, 1'b0, 1'b0);
    end
    checks++; if ({pkt_cnt_0, pkt_cnt_1} !== {32'd3, 32'd3})
      $display("FAIL fair_counts: got %0d/%0d want 3/3", pkt_cnt_0, pkt_cnt_1); else passed++;
  endtask

  // Runs straight after fairness so counters are non-zero going in.
  task automatic test_reset_mid();
    logic [133:0] h, b;
    h = mk(HDR_HEAD, 32'h51); b = mk(HDR_BODY, 32'h52);
    in0_req = 1'b0; in1_req = 1'b1;
    quiet();
    step();
    checks++; if ({in0_gnt, in1_gnt} !== 2'b01) $display("FAIL rstmid_gnt: got %b want 01", {in0_gnt, in1_gnt}); else passed++;
    drive(1, 1'b1, h, 1'b0, 1'b0);
    in1_req = 1'b0;
    step();
    drive(1, 1'b1, b, 1'b0, 1'b0);
    step();
    checks++; if (outw() !== {3'b100, b}) $display("FAIL rstmid_body: got %h want %h", outw(), {3'b100, b}); else passed++;
    drive(1, 1'b1, mk(HDR_BODY, 32'h53), 1'b0, 1'b0);
    rst = 1'b1;
    step();
    checks++; if (outw() !== 137'd0) $display("FAIL rstmid_out: got %h want 0", outw()); else passed++;
    checks++; if ({in0_gnt, in1_gnt} !== 2'b00) $display("FAIL rstmid_gnt_low: got %b want 00", {in0_gnt, in1_gnt}); else passed++;
    checks++; if ({abort_cnt, pkt_cnt_0, pkt_cnt_1} !== 80'd0)
      $display("FAIL rstmid_cnt: got %h want 0", {abort_cnt, pkt_cnt_0, pkt_cnt_1}); else passed++;
    rst = 1'b0;
    quiet();
    step();
    checks++; if (outw() !== 137'd0) $display("FAIL rstmid_no_tail: got %h want 0", outw()); else passed++;
  endtask

  task automatic test_gap_abort();
    logic [133:0] h, forced;
    h = mk(HDR_HEAD, 32'h41);
    forced = {HDR_TAIL, 132'b0};
    do_reset();
    in0_req = 1'b1;
    step();
    drive(0, 1'b1, h, 1'b0, 1'b0);
    in0_req = 1'b0;
    step();
    checks++; if (outw() !== {3'b100, h}) $display("FAIL gap_head: got %h want %h", outw(), {3'b100, h}); else passed++;
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    step(); step(); step();
    checks++; if (in0_gnt !== 1'b1) $display("FAIL gap_held_3: got %b want 1", in0_gnt); else passed++;
    step();
    checks++; if ({in0_gnt, in1_gnt} !== 2'b00) $display("FAIL gap_gnt_drop: got %b want 00", {in0_gnt, in1_gnt}); else passed++;
    checks++; if (outw() !== 137'd0) $display("FAIL gap_pre_tail: got %h want 0", outw()); else passed++;
    drive(0, 1'b1, mk(HDR_BODY, 32'h44), 1'b1, 1'b1);
    step();
    checks++; if (outw() !== {3'b101, forced}) $display("FAIL gap_forced: got %h want %h", outw(), {3'b101, forced}); else passed++;
    checks++; if (abort_cnt !== 16'd1) $display("FAIL gap_abort_cnt: got %0d want 1", abort_cnt); else passed++;
    step();
    checks++; if (outw() !== 137'd0) $display("FAIL gap_late_drop: got %h want 0", outw()); else passed++;
    checks++; if (pkt_cnt_0 !== 32'd0) $display("FAIL gap_pkt0: got %0d want 0", pkt_cnt_0); else passed++;
    quiet();
  endtask

  task automatic test_start_timeout();
    int seen;
    seen = 0;
    do_reset();
    in1_req = 1'b1;
    step();
    checks++; if ({in0_gnt, in1_gnt} !== 2'b01) $display("FAIL start_gnt: got %b want 01", {in0_gnt, in1_gnt}); else passed++;
    in0_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (out_data_wr) seen++;
    end
    checks++; if (in1_gnt !== 1'b1) $display("FAIL start_held_7: got %b want 1", in1_gnt); else passed++;
    step();
    if (out_data_wr) seen++;
    checks++; if ({in0_gnt, in1_gnt} !== 2'b00) $display("FAIL start_gnt_drop: got %b want 00", {in0_gnt, in1_gnt}); else passed++;
    step();
    if (out_data_wr) seen++;
    checks++; if ({in0_gnt, in1_gnt} !== 2'b10) $display("FAIL start_next_gnt: got %b want 10", {in0_gnt, in1_gnt}); else passed++;
    checks++; if (seen !== 0) $display("FAIL start_no_output: got %0d words want 0", seen); else passed++;
    checks++; if (abort_cnt !== 16'd0) $display("FAIL start_abort_cnt: got %0d want 0", abort_cnt); else passed++;
    in0_req = 1'b0; in1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in0_req = 1'b0; in1_req = 1'b0;
    quiet();
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_reset_mid();
    test_gap_abort();
    test_start_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lr_pkt_arbiter.md
Name: lr_pkt_arbiter

Overview:
- Two-requester, packet-granular arbiter in front of the LCM report output.
- Shares one 134-bit UM packet bus between two sources:
  - the pass-through packet stream (source 0);
  - the locally generated beacon-report stream (source 1).
- Grants whole packets with round-robin fairness.
- Watchdogs each grant and forces a clean tail if a granted source stalls mid-packet.
- Output is registered and feeds the lupdate path.

Parameters:
- START_TO, 8, cycles a grantee may take to present its head word before the grant is revoked.
- GAP_TO, 4, max consecutive idle (data_wr=0) cycles allowed inside a granted packet before abort.
- PRIO1_FIRST, 1, round-robin pointer after reset: 1 = source 1 wins the first tie.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in0_req  in  1  source 0 holds a packet ready to send
- in0_data_wr  in  1  source 0 word strobe
- in0_data  in  134  source 0 word; [133:132]: 01 head, 11 body, 10 tail
- in0_data_valid  in  1  source 0 packet-valid flag (on tail)
- in0_data_valid_wr  in  1  source 0 valid strobe (on tail)
- in0_gnt  out  1  source 0 may send
- in1_req, in1_data_wr, in1_data, in1_data_valid, in1_data_valid_wr, in1_gnt: same widths and meanings for source 1
- out_data_wr  out  1  output word strobe
- out_data  out  134  output word
- out_data_valid  out  1  output packet-valid flag
- out_data_valid_wr  out  1  output valid strobe
- abort_cnt  out  16  packets force-terminated (saturating)
- pkt_cnt_0, pkt_cnt_1  out  32  completed packets per source (wrapping)

Behaviour:
- Reset (rst=1 at a clk edge), all outputs 0:
  - state=IDLE;
  - rr pointer per PRIO1_FIRST;
  - all counters and gnt cleared;
  - any in-flight packet is discarded with no forced tail.
- States: IDLE, GNT0, GNT1, ABORT.
- IDLE:
  - req0 or req1 seen: grant to the sole requester, or on a tie to the source the rr pointer favours.
  - Enter GNTx; inx_gnt goes to 1 on the next edge. At most one gnt is high at any time.
  - No req: stay in IDLE, both gnt low.
- GNTx:
  - The source may assert data_wr only while its gnt is high.
  - Words from the non-granted source are ignored; their count is not visible on output.
  - Accepted word (inx_data_wr=1): forwarded with 1-cycle latency.
    - out_data_wr=1.
    - out_data = inx_data, unmodified.
    - valid and valid_wr forwarded as given.
  - Tail word (data_wr=1, hdr=10):
    - gnt drops on the next edge;
    - pkt_cnt_x increments;
    - rr pointer moves to favour the other source;
    - state returns to IDLE, giving one idle bus cycle between packets.
  - Head-only protocol: a packet is not complete until a tail word is seen; a head arriving mid-packet is forwarded as-is.
- Start watchdog:
  - Counts gnt-high cycles before the first word.
  - Reaching START_TO cycles: drop gnt, return to IDLE, no output, rr pointer advanced, abort_cnt unchanged.
- Gap watchdog:
  - Counts consecutive data_wr=0 cycles after the head.
  - Reaching GAP_TO cycles: drop gnt, enter ABORT.
- ABORT:
  - Emit one forced tail: out_data_wr=1, out_data={2'b10,132'b0}, out_data_valid=0, out_data_valid_wr=1.
  - Marks the packet invalid downstream.
  - abort_cnt+1, saturating at 16'hFFFF.
  - Next state IDLE.
  - Late words from the aborted source are dropped.
- Outputs are idle (all 0) in any cycle with no forwarded or forced word.
- Simultaneous tail from GNTx and req from the other source: the next grant is issued from IDLE, one cycle later. No grant is ever issued combinationally.
- pkt_cnt wraps at 2^32. abort_cnt saturates.

Decomposition:
- Shared package lcm_pkg:
  - header codes HDR_HEAD=2'b01, HDR_BODY=2'b11, HDR_TAIL=2'b10;
  - UM word width 134;
  - state enum.
- One natural sub-module: lr_arb_watchdog. It holds the start/gap counter and exposes to_start and to_gap pulses, parameterised by START_TO and GAP_TO.

Test Plan:
- Single source: req0 with a 3-word packet (01,11,10) → in0_gnt=1 one cycle after req. Output matches the input delayed by 1 cycle, tail valid_wr=1. pkt_cnt_0=1, gnt drops after the tail.
- Tie after reset, PRIO1_FIRST=1, req0=req1=1 each holding 2-word packets → source 1 packet first, then source 0. Exactly one idle output cycle between them. pkt_cnt_0=pkt_cnt_1=1.
- Fairness: both requesting continuously for 6 packets → grants alternate 1,0,1,0,1,0, never two in a row from the same source.
- Mid-packet stall: source 0 sends a head, then data_wr=0 for 4 cycles → one forced word {10,0} with valid=0, valid_wr=1. abort_cnt=1. A late body word from source 0 produces no output.
- Start timeout: req1=1 but no data for 8 granted cycles → gnt1 drops, no output, abort_cnt=0. A pending req0 is granted next.
- Reset mid-packet: rst=1 during the body of a source 1 packet → the next cycle has all outputs 0, gnts low, counters 0, no forced tail.
